// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: internal op codes, FSM states and
// the opcode-field constants produced by the CPU main control.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_SLT,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_SLL,
        OP_SRL,
        OP_SRA,
        OP_MUL,
        OP_ILL
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_MUL,
        ST_DONE
    } state_e;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_NONE   = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/alu_decode.sv
// Combinational opcode-field decoder shared across cores: maps the main-control
// aluop/func7/func3 fields onto an internal op code, flagging undecodable ops.
module alu_decode
    import alu_pkg::*;
#(
    parameter bit MUL_EN = 1'b1
) (
    input  logic [1:0] aluop,
    input  logic [6:0] func7,
    input  logic [2:0] func3,
    output op_e        op_c,
    output logic       illegal_c
);

    always_comb begin
        op_c = OP_ILL;
        case (aluop)
            ALUOP_ADD: op_c = OP_ADD;
            ALUOP_BRANCH: begin
                case (func3)
                    3'b000:  op_c = OP_SUB;
                    3'b101:  op_c = OP_SLT;
                    default: op_c = OP_ILL;
                endcase
            end
            ALUOP_RTYPE: begin
                case (func7)
                    F7_BASE: begin
                        case (func3)
                            3'b000:  op_c = OP_ADD;
                            3'b001:  op_c = OP_SLL;
                            3'b010:  op_c = OP_SLT;
                            3'b100:  op_c = OP_XOR;
                            3'b101:  op_c = OP_SRL;
                            3'b110:  op_c = OP_OR;
                            3'b111:  op_c = OP_AND;
                            default: op_c = OP_ILL;
                        endcase
                    end
                    F7_ALT: begin
                        case (func3)
                            3'b000:  op_c = OP_SUB;
                            3'b101:  op_c = OP_SRA;
                            default: op_c = OP_ILL;
                        endcase
                    end
                    F7_MULDIV: begin
                        if (MUL_EN && (func3 == 3'b000)) begin
                            op_c = OP_MUL;
                        end
                    end
                    default: op_c = OP_ILL;
                endcase
            end
            default: op_c = OP_ILL;
        endcase
        illegal_c = (op_c == OP_ILL);
    end

endmodule

// File: rtl/alu_exec_mc.sv
// Multi-cycle ALU execute stage: single-cycle arithmetic/logic, bit-serial
// shifts and shift-add multiply behind a valid/ready request/response pair.
module alu_exec_mc
    import alu_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      aluop,
    input  logic [6:0]      func7,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic            busy
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = SHW + 1;

    op_e             dec_op;
    logic            dec_ill;
    state_e          state, state_nxt;
    op_e             op_q, op_nxt;
    logic [XLEN-1:0] acc, acc_nxt;
    logic [XLEN-1:0] mcand, mcand_nxt;
    logic [XLEN-1:0] mplier, mplier_nxt;
    logic [XLEN-1:0] result_nxt;
    logic [XLEN-1:0] single, shifted, mac;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [SHW-1:0]  shamt;
    logic            zero_nxt, illegal_nxt;

    alu_decode #(.MUL_EN(MUL_EN)) u_decode (
        .aluop     (aluop),
        .func7     (func7),
        .func3     (func3),
        .op_c      (dec_op),
        .illegal_c (dec_ill)
    );

    assign shamt = op_b[SHW-1:0];
    assign mac   = mplier[0] ? (acc + mcand) : acc;

    // Single-step result, taken straight from the request operands at accept
    always_comb begin
        single = '0;
        case (dec_op)
            OP_ADD:  single = op_a + op_b;
            OP_SUB:  single = op_a - op_b;
            OP_SLT:  single = XLEN'($signed(op_a) < $signed(op_b));
            OP_AND:  single = op_a & op_b;
            OP_OR:   single = op_a | op_b;
            OP_XOR:  single = op_a ^ op_b;
            default: single = '0;
        endcase
    end

    always_comb begin
        shifted = acc;
        case (op_q)
            OP_SLL:  shifted = acc << 1;
            OP_SRL:  shifted = acc >> 1;
            OP_SRA:  shifted = {acc[XLEN-1], acc[XLEN-1:1]};
            default: shifted = acc;
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt   = state;
        op_nxt      = op_q;
        acc_nxt     = acc;
        mcand_nxt   = mcand;
        mplier_nxt  = mplier;
        cnt_nxt     = cnt;
        result_nxt  = result;
        zero_nxt    = zero;
        illegal_nxt = illegal;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    op_nxt      = dec_op;
                    illegal_nxt = dec_ill;
                    case (dec_op)
                        OP_SLL, OP_SRL, OP_SRA: begin
                            acc_nxt = op_a;
                            cnt_nxt = CW'(shamt);
                            if (shamt == '0) begin
                                result_nxt = op_a;
                                zero_nxt   = (op_a == '0);
                                state_nxt  = ST_DONE;
                            end else begin
                                state_nxt = ST_SHIFT;
                            end
                        end
                        OP_MUL: begin
                            acc_nxt    = '0;
                            mcand_nxt  = op_a;
                            mplier_nxt = op_b;
                            cnt_nxt    = CW'(XLEN);
                            state_nxt  = ST_MUL;
                        end
                        default: begin
                            result_nxt = single;
                            zero_nxt   = (single == '0);
                            state_nxt  = ST_DONE;
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                acc_nxt = shifted;
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    result_nxt = shifted;
                    zero_nxt   = (shifted == '0);
                    state_nxt  = ST_DONE;
                end
            end
            ST_MUL: begin
                acc_nxt    = mac;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                cnt_nxt    = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    result_nxt = mac;
                    zero_nxt   = (mac == '0);
                    state_nxt  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers and registered handshake flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= OP_ADD;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            op_q      <= op_nxt;
            acc       <= acc_nxt;
            mcand     <= mcand_nxt;
            mplier    <= mplier_nxt;
            cnt       <= cnt_nxt;
            result    <= result_nxt;
            zero      <= zero_nxt;
            illegal   <= illegal_nxt;
            in_ready  <= (state_nxt == ST_IDLE);
            out_valid <= (state_nxt == ST_DONE);
            busy      <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_alu_exec_mc.sv
// Randomized and directed bench for alu_exec_mc against a queue-based
// transaction model of results, flags and latency.
module tb_alu_exec_mc;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      aluop = '0;
    logic [6:0]      func7 = '0;
    logic [2:0]      func3 = '0;
    logic [XLEN-1:0] op_a = '0;
    logic [XLEN-1:0] op_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
    logic            busy;

    logic            in_valid0 = 1'b0;
    logic            in_ready0;
    logic            out_valid0;
    logic            out_ready0 = 1'b1;
    logic [XLEN-1:0] result0;
    logic            zero0;
    logic            illegal0;
    logic            busy0;

    alu_exec_mc #(.XLEN(XLEN), .MUL_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .func7(func7), .func3(func3), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .illegal(illegal), .busy(busy)
    );

    alu_exec_mc #(.XLEN(XLEN), .MUL_EN(1'b0)) u_dut_nomul (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .aluop(aluop), .func7(func7), .func3(func3), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid0), .out_ready(out_ready0), .result(result0),
        .zero(zero0), .illegal(illegal0), .busy(busy0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        bit          ill;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   run    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference semantics: result, illegal flag and accept-to-valid latency
    function automatic void model(input logic [1:0] ao, input logic [6:0] f7,
                                  input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b, input bit mul_en,
                                  output logic [31:0] r, output bit ill,
                                  output int lat);
        int sh;
        sh  = int'(b[4:0]);
        r   = '0;
        ill = 1'b0;
        lat = 1;
        if (ao == 2'b00) begin
            r = a + b;
        end else if (ao == 2'b01) begin
            if (f3 == 3'd0)      r = a - b;
            else if (f3 == 3'd5) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            else                 ill = 1'b1;
        end else if (ao == 2'b10 && f7 == 7'h00) begin
            case (f3)
                3'd0: r = a + b;
                3'd1: begin r = a << sh; lat = sh + 1; end
                3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: begin r = a >> sh; lat = sh + 1; end
                3'd6: r = a | b;
                3'd7: r = a & b;
                default: ill = 1'b1;
            endcase
        end else if (ao == 2'b10 && f7 == 7'h20) begin
            if (f3 == 3'd0) begin
                r = a - b;
            end else if (f3 == 3'd5) begin
                r   = 32'($signed(a) >>> sh);
                lat = sh + 1;
            end else begin
                ill = 1'b1;
            end
        end else if (ao == 2'b10 && f7 == 7'h01 && f3 == 3'd0 && mul_en) begin
            r   = a * b;
            lat = XLEN + 1;
        end else begin
            ill = 1'b1;
        end
        if (ill) r = '0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of handshake flags and held results
    always @(negedge clk) begin
        bit infl;
        bit eov;
        #1;
        if (run) begin
            infl = 1'b0;
            eov  = 1'b0;
            if (q.size() > 0) begin
                if (cyc >= q[0].acc) begin
                    infl = 1'b1;
                    eov  = (cyc - q[0].acc + 1) >= q[0].lat;
                end
            end
            chk("in_ready", in_ready, !infl);
            chk("busy", busy, infl);
            chk("out_valid", out_valid, eov);
            if (infl && eov && out_valid) begin
                chk("result", result, q[0].r);
                chk("zero", zero, q[0].r == 32'd0);
                chk("illegal", illegal, q[0].ill);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic scramble();
        aluop = 2'($urandom);
        func7 = 7'($urandom);
        func3 = 3'($urandom);
        op_a  = $urandom;
        op_b  = $urandom;
    endtask

    task automatic start_op(input logic [1:0] ao, input logic [6:0] f7, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b, input bit ro,
                            output bit ok);
        exp_t e;
        int   n;
        aluop = ao; func7 = f7; func3 = f3; op_a = a; op_b = b;
        in_valid  = 1'b1;
        out_ready = ro;
        n = 0;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        if (!ok) begin
            chk("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
        end else begin
            model(ao, f7, f3, a, b, 1'b1, e.r, e.ill, e.lat);
            e.acc = cyc + 1;
            q.push_back(e);
            @(negedge clk);
            in_valid = 1'b0;
            scramble();
        end
    endtask

    task automatic finish_op(input int stall);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            scramble();
            n++;
        end
        if (!out_valid) begin
            chk("done_timeout", 64'd0, 64'd1);
            rst = 1'b1;
            q.delete();
            @(negedge clk);
            rst = 1'b0;
        end else begin
            for (int i = 0; i < stall; i++) begin
                in_valid = 1'b1;
                scramble();
                @(negedge clk);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        bit          ill;
        int          lat;
        bit          ok;
        int          stall;
        logic [6:0]  f7;

        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 0);
        chk("rst_illegal", illegal, 0);

        model(2'b10, 7'h00, 3'd0, 32'd7, 32'd5, 1'b1, r, ill, lat);
        chk("pin_add", r, 32'd12); chk("pin_add_lat", lat, 1);
        model(2'b01, 7'h00, 3'd0, 32'h1234, 32'h1234, 1'b1, r, ill, lat);
        chk("pin_sub", r, 32'd0); chk("pin_sub_ill", ill, 0);
        model(2'b10, 7'h20, 3'd5, 32'h8000_0000, 32'd4, 1'b1, r, ill, lat);
        chk("pin_sra", r, 32'hF800_0000); chk("pin_sra_lat", lat, 5);
        model(2'b10, 7'h20, 3'd5, 32'h8000_0000, 32'd0, 1'b1, r, ill, lat);
        chk("pin_sra0", r, 32'h8000_0000); chk("pin_sra0_lat", lat, 1);
        model(2'b10, 7'h01, 3'd0, 32'hFFFF_FFFF, 32'd3, 1'b1, r, ill, lat);
        chk("pin_mul", r, 32'hFFFF_FFFD); chk("pin_mul_lat", lat, 33);
        model(2'b10, 7'h01, 3'd0, 32'hFFFF_FFFF, 32'd3, 1'b0, r, ill, lat);
        chk("pin_nomul_ill", ill, 1); chk("pin_nomul_r", r, 0);

        @(negedge clk);
        rst = 1'b0;
        run = 1'b1;
        @(negedge clk);

        start_op(2'b10, 7'h00, 3'd0, 32'd7, 32'd5, 1'b1, ok);
        if (ok) finish_op(0);
        start_op(2'b01, 7'h00, 3'd0, 32'h1234, 32'h1234, 1'b1, ok);
        if (ok) finish_op(0);
        start_op(2'b10, 7'h20, 3'd5, 32'h8000_0000, 32'd4, 1'b1, ok);
        if (ok) finish_op(0);
        start_op(2'b10, 7'h20, 3'd5, 32'h8000_0000, 32'd0, 1'b1, ok);
        if (ok) finish_op(0);
        start_op(2'b10, 7'h01, 3'd0, 32'hFFFF_FFFF, 32'd3, 1'b1, ok);
        if (ok) finish_op(0);
        start_op(2'b11, 7'h00, 3'd0, 32'd9, 32'd9, 1'b1, ok);
        if (ok) finish_op(0);
        start_op(2'b10, 7'h00, 3'd6, 32'h00F0, 32'h0F00, 1'b0, ok);
        if (ok) finish_op(10);

        aluop = 2'b10; func7 = 7'h01; func3 = 3'd0;
        op_a = 32'hFFFF_FFFF; op_b = 32'd3;
        chk("nomul_idle_ready", in_ready0, 1);
        in_valid0 = 1'b1;
        @(negedge clk);
        in_valid0 = 1'b0;
        chk("nomul_out_valid", out_valid0, 1);
        chk("nomul_illegal", illegal0, 1);
        chk("nomul_result", result0, 0);
        chk("nomul_zero", zero0, 1);
        @(negedge clk);
        chk("nomul_back_idle", in_ready0, 1);
        chk("nomul_valid_drop", out_valid0, 0);

        start_op(2'b10, 7'h01, 3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, ok);
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        q.delete();
        #1;
        chk("rstmul_in_ready", in_ready, 1);
        chk("rstmul_busy", busy, 0);
        chk("rstmul_out_valid", out_valid, 0);
        chk("rstmul_result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_op(2'b00, 7'h00, 3'd0, 32'd100, 32'd23, 1'b1, ok);
        if (ok) finish_op(0);

        for (int k = 0; k < 200; k++) begin
            case ($urandom_range(0, 3))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                2:       f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            start_op(2'($urandom_range(0, 3)), f7, 3'($urandom), $urandom, $urandom,
                     stall == 0, ok);
            if (ok) finish_op(stall);
        end

        repeat (3) @(negedge clk);
        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
